// File: rtl/z80_mmu_ctx.sv
// z80_mmu_ctx: multi-context Z80 paging MMU.
//   Holds NUM_CTX sets of NUM_PAGES slot registers (block number plus an
//   optional write-protect bit). The CPU page is translated through the
//   active context, software edits a separately selected edit context, and a
//   sequential copy engine clones a source context into the edit context.
// Optional feature macro: Z80_MMU_WP_EN (per-slot write-protect bit in slot
//   bit 7, o_wp output and latched write-fault interrupt). Without it o_wp,
//   fault pending and the FAULT register are constant zero.
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_cs_n, i_wr_n          register select / write strobe (active low)
//   i_addr, i_data, o_data  register address, write data, comb. read data
//   i_page, i_mem_wr_n      CPU page to translate, CPU memory write strobe
//   o_block, o_wp           comb. translated block and write-protect flag
//   o_fault_irq, o_busy     registered fault pending / copy engine running
module z80_mmu_ctx #(
    parameter int unsigned NUM_PAGES = 4,
    parameter int unsigned NUM_CTX   = 2,
    parameter int unsigned BLOCK_W   = 7
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_cs_n,
    input  logic                           i_wr_n,
    input  logic [$clog2(NUM_PAGES):0]     i_addr,
    input  logic [7:0]                     i_data,
    output logic [7:0]                     o_data,
    input  logic [$clog2(NUM_PAGES)-1:0]   i_page,
    input  logic                           i_mem_wr_n,
    output logic [BLOCK_W-1:0]             o_block,
    output logic                           o_wp,
    output logic                           o_fault_irq,
    output logic                           o_busy
);
    localparam int unsigned PAGE_W = $clog2(NUM_PAGES);
    localparam int unsigned CTX_W  = $clog2(NUM_CTX);
    localparam int unsigned SLOT_W = CTX_W + PAGE_W;
    localparam int unsigned NSLOT  = NUM_CTX * NUM_PAGES;

    typedef enum logic {S_IDLE, S_COPY} state_t;

    state_t             state_q, state_d;
    logic [PAGE_W-1:0]  cnt_q, cnt_d;
    logic [CTX_W-1:0]   src_q, src_d;
    logic [CTX_W-1:0]   dst_q, dst_d;
    logic [CTX_W-1:0]   act_q, act_d;
    logic [CTX_W-1:0]   edit_q, edit_d;
    logic               busy_q, busy_d;
    logic [BLOCK_W-1:0] blk_q [NSLOT];
    logic [BLOCK_W-1:0] blk_d [NSLOT];

    logic               pend_q;
    logic [PAGE_W-1:0]  fault_page_q;
    logic [CTX_W-1:0]   fault_ctx_q;
    logic               rd_wp_c;
    logic               tr_wp_c;

    logic               reg_wr_c;
    logic [PAGE_W-1:0]  idx_c;
    logic               slot_wr_c, ctrl_wr_c, copy_wr_c;
    logic [SLOT_W-1:0]  edit_slot_c, act_slot_c, copy_src_c, copy_dst_c;

    // Register decode; slot index is {ctx, page}
    always_comb begin
        reg_wr_c    = !i_cs_n && !i_wr_n;
        idx_c       = i_addr[PAGE_W-1:0];
        slot_wr_c   = reg_wr_c && !i_addr[PAGE_W] && !busy_q;
        ctrl_wr_c   = reg_wr_c && i_addr[PAGE_W] && (idx_c == PAGE_W'(0));
        copy_wr_c   = reg_wr_c && i_addr[PAGE_W] && (idx_c == PAGE_W'(1)) && !busy_q;
        edit_slot_c = {edit_q, idx_c};
        act_slot_c  = {act_q, i_page};
        copy_src_c  = {src_q, cnt_q};
        copy_dst_c  = {dst_q, cnt_q};
    end

    // Next-state: context select, slot writes and the copy engine
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        act_d   = act_q;
        edit_d  = edit_q;
        blk_d   = blk_q;
        if (ctrl_wr_c) begin
            act_d = i_data[CTX_W-1:0];
            if (!busy_q) begin
                edit_d = i_data[4 +: CTX_W];
            end
        end
        if (slot_wr_c) begin
            blk_d[edit_slot_c] = i_data[BLOCK_W-1:0];
        end
        case (state_q)
            S_IDLE: begin
                if (copy_wr_c) begin
                    state_d = S_COPY;
                    src_d   = i_data[CTX_W-1:0];
                    dst_d   = edit_q;
                    cnt_d   = '0;
                end
            end
            S_COPY: begin
                blk_d[copy_dst_c] = blk_q[copy_src_c];
                cnt_d = cnt_q + PAGE_W'(1);
                if (cnt_q == PAGE_W'(NUM_PAGES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_COPY);
    end

    // State registers; reset restores the identity map in every context
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            act_q   <= '0;
            edit_q  <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                blk_q[i] <= BLOCK_W'(i % NUM_PAGES);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            act_q   <= act_d;
            edit_q  <= edit_d;
            busy_q  <= busy_d;
            blk_q   <= blk_d;
        end
    end

`ifdef Z80_MMU_WP_EN
    logic              wp_q [NSLOT];
    logic              wp_d [NSLOT];
    logic              pend_d;
    logic [PAGE_W-1:0] fault_page_d;
    logic [CTX_W-1:0]  fault_ctx_d;
    logic              clr_c, flt_c;

    // Write-protect bits follow slot writes and copies; fault latch on top
    always_comb begin
        wp_d         = wp_q;
        pend_d       = pend_q;
        fault_page_d = fault_page_q;
        fault_ctx_d  = fault_ctx_q;
        clr_c = reg_wr_c && i_addr[PAGE_W] && (idx_c == PAGE_W'(2)) && i_data[1];
        flt_c = !i_mem_wr_n && tr_wp_c;
        if (slot_wr_c) begin
            wp_d[edit_slot_c] = i_data[7];
        end
        if (state_q == S_COPY) begin
            wp_d[copy_dst_c] = wp_q[copy_src_c];
        end
        if (clr_c) begin
            pend_d = 1'b0;
        end
        // A new fault beats a same-edge clear and re-arms the capture
        if (flt_c) begin
            pend_d = 1'b1;
            if (!pend_q || clr_c) begin
                fault_page_d = i_page;
                fault_ctx_d  = act_q;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pend_q       <= 1'b0;
            fault_page_q <= '0;
            fault_ctx_q  <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                wp_q[i] <= 1'b0;
            end
        end else begin
            pend_q       <= pend_d;
            fault_page_q <= fault_page_d;
            fault_ctx_q  <= fault_ctx_d;
            wp_q         <= wp_d;
        end
    end

    assign rd_wp_c = wp_q[edit_slot_c];
    assign tr_wp_c = wp_q[act_slot_c];
`else
    logic unused_c;

    assign pend_q       = 1'b0;
    assign fault_page_q = '0;
    assign fault_ctx_q  = '0;
    assign rd_wp_c      = 1'b0;
    assign tr_wp_c      = 1'b0;
    assign unused_c     = ^{i_data, i_mem_wr_n};
`endif

    // Register read mux
    always_comb begin
        o_data = 8'h00;
        if (!i_addr[PAGE_W]) begin
            o_data = 8'(blk_q[edit_slot_c]);
            if (rd_wp_c) begin
                o_data[7] = 1'b1;
            end
        end else begin
            case (idx_c)
                PAGE_W'(0): o_data = {4'(edit_q), 4'(act_q)};
                PAGE_W'(1): o_data = {7'b0, busy_q};
                PAGE_W'(2): o_data = {6'b0, pend_q, busy_q};
                PAGE_W'(3): o_data = 8'({4'(fault_ctx_q), fault_page_q});
                default:    o_data = 8'h00;
            endcase
        end
    end

    assign o_block     = blk_q[act_slot_c];
    assign o_wp        = tr_wp_c;
    assign o_fault_irq = pend_q;
    assign o_busy      = busy_q;

endmodule
